adpll_lock_detector: RTL

- Lock-qualification stage directly downstream of the network ADPLL node.
- Consumes the node's combined phase error and signed DCO control code, sampled once per divided-clock period.
- Decides whether the loop has acquired and holds lock; raises `locked_o` and a one-cycle `lost_lock_o` pulse for the network supervisor.
- Flags when the DCO control code sits on a rail.

---
 rtl/adpll_lock_detector.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/adpll_lock_detector.sv
// rtl/adpll_lock_detector.sv - ADPLL lock qualification: phase-error / DCO-code hysteresis FSM
module adpll_lock_detector #(
    parameter int PDET_WIDTH   = 8,
    parameter int DCO_CC_WIDTH = 9,
    parameter int ERR_TOL      = 2,
    parameter int CC_TOL       = 4,
    parameter int LOCK_COUNT   = 16,
    parameter int UNLOCK_COUNT = 4,
    parameter int CNT_WIDTH    = 8
) (
    input  logic                           fpga_clk_i,
    input  logic                           reset_i,
    input  logic                           enable_i,
    input  logic                           gen_div8_i,
    input  logic signed [PDET_WIDTH-1:0]   error_i,
    input  logic signed [DCO_CC_WIDTH-1:0] dco_cc_i,
    output logic                           locked_o,
    output logic [1:0]                     lock_state_o,
    output logic                           lost_lock_o,
    output logic                           rail_o,
    output logic signed [DCO_CC_WIDTH-1:0] cc_ref_o
);

    localparam int DW = DCO_CC_WIDTH + 1;
    localparam logic [PDET_WIDTH-1:0]   ERR_MAX = {1'b0, {(PDET_WIDTH-1){1'b1}}};
    localparam logic [PDET_WIDTH-1:0]   ERR_MIN = {1'b1, {(PDET_WIDTH-1){1'b0}}};
    localparam logic [DCO_CC_WIDTH-1:0] CC_MAX  = {1'b0, {(DCO_CC_WIDTH-1){1'b1}}};
    localparam logic [DCO_CC_WIDTH-1:0] CC_MIN  = {1'b1, {(DCO_CC_WIDTH-1){1'b0}}};
    localparam logic [CNT_WIDTH-1:0]    LOCK_LAST   = CNT_WIDTH'(LOCK_COUNT - 1);
    localparam logic [CNT_WIDTH-1:0]    UNLOCK_LAST = CNT_WIDTH'(UNLOCK_COUNT - 1);

    typedef enum logic [1:0] {
        UNLOCKED = 2'b00,
        ACQUIRE  = 2'b01,
        LOCKED   = 2'b10
    } state_t;

    logic                    sync1_q, sync1_d, sync2_q, sync2_d;
    logic                    edge_q, edge_d, strobe_q, strobe_d;
    state_t                  state_q, state_d;
    logic [CNT_WIDTH-1:0]    cnt_q, cnt_d;
    logic                    lost_q, lost_d, rail_q, rail_d;
    logic [DCO_CC_WIDTH-1:0] cc_ref_q, cc_ref_d;

    logic [PDET_WIDTH-1:0]   abs_err;
    logic [DW-1:0]           delta, abs_delta;
    logic                    rail, err_ok, cc_ok, good;

    always_comb begin
        if (error_i == ERR_MIN)
            abs_err = ERR_MAX;
        else if (error_i[PDET_WIDTH-1])
            abs_err = -error_i;
        else
            abs_err = error_i;
        // One extra bit keeps the difference of two full-range codes exact
        delta     = {dco_cc_i[DCO_CC_WIDTH-1], dco_cc_i} - {cc_ref_q[DCO_CC_WIDTH-1], cc_ref_q};
        abs_delta = delta[DW-1] ? -delta : delta;
        rail      = (dco_cc_i == CC_MAX) || (dco_cc_i == CC_MIN);
        err_ok    = abs_err <= PDET_WIDTH'(ERR_TOL);
        cc_ok     = abs_delta <= DW'(CC_TOL);
        good      = err_ok && cc_ok && !rail;
    end

    always_comb begin
        sync1_d  = gen_div8_i;
        sync2_d  = sync1_q;
        edge_d   = sync2_q;
        strobe_d = sync2_q & ~edge_q;
        state_d  = state_q;
        cnt_d    = cnt_q;
        lost_d   = 1'b0;
        rail_d   = rail_q;
        cc_ref_d = cc_ref_q;
        if (!enable_i) begin
            state_d = UNLOCKED;
            cnt_d   = '0;
        end else if (strobe_q) begin
            rail_d = rail;
            case (state_q)
                UNLOCKED: begin
                    cc_ref_d = dco_cc_i;
                    if (err_ok && !rail) begin
                        state_d = ACQUIRE;
                        cnt_d   = CNT_WIDTH'(1);
                    end else begin
                        cnt_d   = '0;
                    end
                end
                ACQUIRE: begin
                    if (!good) begin
                        state_d = UNLOCKED;
                        cnt_d   = '0;
                    end else if (cnt_q == LOCK_LAST) begin
                        state_d = LOCKED;
                        cnt_d   = '0;
                    end else begin
                        cnt_d   = cnt_q + 1'b1;
                    end
                end
                LOCKED: begin
                    // A railed DCO cannot be tracking, so skip the hysteresis
                    if (rail || (!good && cnt_q == UNLOCK_LAST)) begin
                        state_d = UNLOCKED;
                        cnt_d   = '0;
                        lost_d  = 1'b1;
                    end else if (good) begin
                        cnt_d   = '0;
                    end else begin
                        cnt_d   = cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_d = UNLOCKED;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge fpga_clk_i or negedge reset_i) begin
        if (!reset_i) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            edge_q   <= 1'b0;
            strobe_q <= 1'b0;
            state_q  <= UNLOCKED;
            cnt_q    <= '0;
            lost_q   <= 1'b0;
            rail_q   <= 1'b0;
            cc_ref_q <= '0;
        end else begin
            sync1_q  <= sync1_d;
            sync2_q  <= sync2_d;
            edge_q   <= edge_d;
            strobe_q <= strobe_d;
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            lost_q   <= lost_d;
            rail_q   <= rail_d;
            cc_ref_q <= cc_ref_d;
        end
    end

    assign locked_o     = (state_q == LOCKED);
    assign lock_state_o = state_q;
    assign lost_lock_o  = lost_q;
    assign rail_o       = rail_q;
    assign cc_ref_o     = cc_ref_q;

endmodule
